// File: rtl/mult_digit_serial.sv
// Digit-serial unsigned multiplier: one DIGIT x DIGIT partial product per clock,
// shifted into place and accumulated into a 2*WIDTH product, with start/ready/busy/done handshake.
module mult_digit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int NSTEP = NDIG * NDIG;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        step_q, step_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    int unsigned          dig_i_s, dig_j_s;
    logic [WIDTH-1:0]     a_shift_s, b_shift_s;
    logic [DIGIT-1:0]     a_dig_s, b_dig_s;
    logic [2*DIGIT-1:0]   pp_s;
    logic [2*WIDTH-1:0]   term_s;
    logic                 last_step_s;

    // Digit pair selection and shifted partial product for the current step
    always_comb begin
        dig_i_s     = 32'(step_q) / NDIG;
        dig_j_s     = 32'(step_q) % NDIG;
        a_shift_s   = a_q >> (dig_i_s * DIGIT);
        b_shift_s   = b_q >> (dig_j_s * DIGIT);
        a_dig_s     = a_shift_s[DIGIT-1:0];
        b_dig_s     = b_shift_s[DIGIT-1:0];
        pp_s        = (2*DIGIT)'(a_dig_s) * (2*DIGIT)'(b_dig_s);
        term_s      = (2*WIDTH)'(pp_s) << (DIGIT * (dig_i_s + dig_j_s));
        last_step_s = (step_q == SW'(NSTEP - 1));
    end

    // Next-state, accumulation and handshake outputs
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    step_d    = '0;
                    a_d       = a;
                    b_d       = b;
                    product_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                product_d = product_q + term_s;
                // step stays on the last index; only an accept rewinds it
                if (last_step_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    step_d    = '0;
                    a_d       = a;
                    b_d       = b;
                    product_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase

        ready_d = (state_d != ST_RUN);
        busy_d  = (state_d == ST_RUN);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mult_digit_serial.sv
// Bench for mult_digit_serial: 8/4, 16/4 and 8/8 instances checked against a plain a*b model
// with latency NDIG^2 edges from accept.
module tb_mult_digit_serial;

    logic clk;
    logic rst_n;

    logic        start8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic        start16, ready16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    logic        start1, ready1, busy1, done1;
    logic [7:0]  a1, b1;
    logic [15:0] product1;

    int n_pass;
    int n_total;

    mult_digit_serial #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .product(product8)
    );

    mult_digit_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .ready(ready16), .busy(busy16), .done(done16), .product(product16)
    );

    mult_digit_serial #(.WIDTH(8), .DIGIT(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1), .product(product1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launch one 8-bit operation from a ready cycle; returns product seen with done,
    // edges from accept to done, and RUN cycles with busy=1.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input bit scramble,
                          output logic [15:0] prod, output int lat, output int busy_cnt);
        start8 = 1'b1; a8 = av; b8 = bv;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0; busy_cnt = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            if (scramble) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                start8 = (lat == 1);
            end
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0;
        prod = product8;
    endtask

    task automatic do_op16(input logic [15:0] av, input logic [15:0] bv,
                           output logic [31:0] prod, output int lat);
        start16 = 1'b1; a16 = av; b16 = bv;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        while (done16 !== 1'b1 && lat < 60) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        prod = product16;
    endtask

    task automatic do_op1(input logic [7:0] av, input logic [7:0] bv,
                          output logic [15:0] prod, output int lat);
        start1 = 1'b1; a1 = av; b1 = bv;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = product1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total++;
        if ({ready8, busy8, done8, product8} !== {1'b1, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset8 r/b/d/p=%b%b%b %h required 100 0000", ready8, busy8, done8, product8);
        else n_pass++;
        n_total++;
        if ({ready16, busy16, done16, product16} !== {1'b1, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset16 r/b/d/p=%b%b%b %h required 100 00000000", ready16, busy16, done16, product16);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_max_operands();
        logic [15:0] p; int lat; int bc;
        do_op8(8'hFF, 8'hFF, 1'b0, p, lat, bc);
        n_total++;
        if (p !== 16'hFE01) $display("FAIL max_product got %h required fe01", p); else n_pass++;
        n_total++;
        if (lat !== 4) $display("FAIL max_latency got %0d required 4", lat); else n_pass++;
        n_total++;
        if (bc !== 4) $display("FAIL max_busy_cycles got %0d required 4", bc); else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({done8, ready8, busy8, product8} !== {1'b0, 1'b1, 1'b0, 16'hFE01})
            $display("FAIL hold_after_done d/r/b/p=%b%b%b %h required 010 fe01", done8, ready8, busy8, product8);
        else n_pass++;
    endtask

    task automatic test_patterns();
        logic [7:0] ta [6] = '{8'h00, 8'hC3, 8'h01, 8'h80, 8'h00, 8'hAA};
        logic [7:0] tb [6] = '{8'h5A, 8'h00, 8'hA5, 8'h02, 8'h00, 8'h55};
        logic [15:0] p; logic [15:0] exp; int lat; int bc;
        for (int k = 0; k < 6; k++) begin
            do_op8(ta[k], tb[k], 1'b0, p, lat, bc);
            exp = 16'(ta[k]) * 16'(tb[k]);
            n_total++;
            if (p !== exp || lat !== 4)
                $display("FAIL pattern%0d got %h lat %0d required %h lat 4", k, p, lat, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        do_op8(8'h01, 8'hA5, 1'b0, p, lat, bc);
        n_total++;
        if (p !== 16'h00A5) $display("FAIL one_times got %h required 00a5", p); else n_pass++;
        do_op8(8'h80, 8'h02, 1'b0, p, lat, bc);
        n_total++;
        if (p !== 16'h0100) $display("FAIL msb_times got %h required 0100", p); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int times [4];
        logic [15:0] prods [4];
        int n;
        n = 0;
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        @(posedge clk); #1;
        a8 = 8'h0F; b8 = 8'h10;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 && n < 4) begin
                times[n] = c; prods[n] = product8; n++;
                if (n >= 2) start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        n_total++;
        if (n !== 2) $display("FAIL b2b_done_count got %0d required 2", n); else n_pass++;
        if (n >= 2) begin
            n_total++;
            if (times[0] !== 4 || times[1] - times[0] !== 5)
                $display("FAIL b2b_spacing got %0d,%0d required 4,9", times[0], times[1]);
            else n_pass++;
            n_total++;
            if (prods[0] !== 16'h03A8 || prods[1] !== 16'h00F0)
                $display("FAIL b2b_products got %h,%h required 03a8,00f0", prods[0], prods[1]);
            else n_pass++;
        end
    endtask

    task automatic test_operand_latch();
        logic [7:0] av, bv; logic [15:0] p; int lat; int bc; int bad;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            av = 8'($urandom); bv = 8'($urandom);
            do_op8(av, bv, 1'b1, p, lat, bc);
            n_total++;
            if (p !== 16'(av) * 16'(bv) || lat !== 4) begin
                $display("FAIL latch%0d %h*%h got %h lat %0d required %h lat 4",
                         k, av, bv, p, lat, 16'(av) * 16'(bv));
                bad++;
            end else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p; int lat; int bc; int seen_done;
        start8 = 1'b1; a8 = 8'hEE; b8 = 8'hDD;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({product8, busy8, done8, ready8} !== {16'h0000, 1'b0, 1'b0, 1'b1})
            $display("FAIL async_reset p/b/d/r=%h %b%b%b required 0000 001", product8, busy8, done8, ready8);
        else n_pass++;
        seen_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) seen_done++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) seen_done++;
        end
        n_total++;
        if (seen_done !== 0) $display("FAIL abort_no_done got %0d pulses required 0", seen_done); else n_pass++;
        do_op8(8'h37, 8'h5B, 1'b0, p, lat, bc);
        n_total++;
        if (p !== 16'h37 * 16'h5B || lat !== 4)
            $display("FAIL after_reset got %h lat %0d required %h lat 4", p, lat, 16'h37 * 16'h5B);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_wide16();
        logic [15:0] av, bv; logic [31:0] p; int lat;
        do_op16(16'hFFFF, 16'hFFFF, p, lat);
        n_total++;
        if (p !== 32'hFFFE0001 || lat !== 16)
            $display("FAIL wide_max got %h lat %0d required fffe0001 lat 16", p, lat);
        else n_pass++;
        for (int k = 0; k < 1000; k++) begin
            av = 16'($urandom); bv = 16'($urandom);
            do_op16(av, bv, p, lat);
            n_total++;
            if (p !== 32'(av) * 32'(bv) || lat !== 16)
                $display("FAIL wide_rand%0d %h*%h got %h lat %0d required %h lat 16",
                         k, av, bv, p, lat, 32'(av) * 32'(bv));
            else n_pass++;
        end
        start16 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_digit();
        logic [7:0] av, bv; logic [15:0] p; int lat;
        for (int k = 0; k < 40; k++) begin
            av = (k == 0) ? 8'hFF : 8'($urandom);
            bv = (k == 0) ? 8'hFF : 8'($urandom);
            do_op1(av, bv, p, lat);
            n_total++;
            if (p !== 16'(av) * 16'(bv) || lat !== 1)
                $display("FAIL single%0d %h*%h got %h lat %0d required %h lat 1",
                         k, av, bv, p, lat, 16'(av) * 16'(bv));
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        start1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
        test_reset();
        test_max_operands();
        test_patterns();
        test_back_to_back();
        test_operand_latch();
        test_reset_mid_run();
        test_wide16();
        test_single_digit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
